paint_input_bank: RTL and testbench
===================================

// Module: paint_input_bank
// PURPOSE
//  Parametrised N-channel conditioner for paint-board buttons/switches; replaces per-input debouncer/switch instances.
//  Per channel: synchroniser, debounce, press/release pulses, toggle latch, long-press flag, auto-repeat pulses.
//  Also tracks the most recently pressed channel (drives colour/tool select). Sits between board pins and paint control logic.
// PARAMETERS
//  N_CH          12          number of input channels (1..32)
//  SYNC_STAGES   2           synchroniser flops per channel (>=2)
//  DEBOUNCE_CYC  1_000_000   cycles input must be stable to change level (10 ms @ 100 MHz); >=2
//  HOLD_CYC      50_000_000  cycles level held high before long_press asserts (0.5 s); >=2
//  REPEAT_CYC    10_000_000  repeat_pulse period once long_press is set (0.1 s); >=2
// PORTS
//  clk            in   1                 100 MHz system clock
//  clr_n          in   1                 reset, asynchronous, active-low
//  raw_in         in   N_CH              asynchronous button/switch pins, active-high
//  level_out      out  N_CH              debounced level
//  press_pulse    out  N_CH              1-cycle pulse on debounced rising edge
//  release_pulse  out  N_CH              1-cycle pulse on debounced falling edge
//  toggle_out     out  N_CH              flips on each press_pulse
//  long_press     out  N_CH              high while level held >= HOLD_CYC
//  repeat_pulse   out  N_CH              1-cycle pulse at hold threshold, then every REPEAT_CYC
//  sel_idx        out  $clog2(N_CH)      index of last pressed channel
//  sel_valid      out  1                 set by first press after reset; sticky
// BEHAVIOUR
//  - Reset: every output and internal flop 0, including synchroniser chains and counters.
//  - Sync: raw_in[i] passes SYNC_STAGES flops -> s[i]; no other logic touches raw_in.
//  - Debounce counter dcnt, width $clog2(DEBOUNCE_CYC):
//     s==level: dcnt<=0. s!=level: dcnt++; on the cycle dcnt==DEBOUNCE_CYC-1, level<=s and dcnt<=0.
//     A glitch shorter than DEBOUNCE_CYC cycles restarts the count and never changes level.
//  - Latency: stable raw edge -> level_out change = SYNC_STAGES+DEBOUNCE_CYC cycles.
//  - press/release_pulse registered: high the cycle after level changes, for exactly 1 cycle.
//  - toggle_out flips in the same cycle press_pulse is high.
//  - Hold counter hcnt, width $clog2(max(HOLD_CYC,REPEAT_CYC)), cleared when level==0:
//     IDLE (level 0) -> HOLD on level rise.
//     HOLD: hcnt++; at hcnt==HOLD_CYC-1: long_press<=1, repeat_pulse 1 cycle, hcnt<=0, go REPEAT.
//     REPEAT: hcnt++; at hcnt==REPEAT_CYC-1: repeat_pulse 1 cycle, hcnt<=0.
//     Level fall in any state -> IDLE; long_press<=0 that cycle; no repeat_pulse that cycle.
//  - Selection: any press_pulse set -> sel_idx <= lowest index among simultaneous presses, sel_valid<=1.
//     No press -> hold. A release never changes sel_idx.
//  - Input held high through reset: after clr_n rises, press_pulse follows SYNC_STAGES+DEBOUNCE_CYC+1 cycles later.
//  - Reset asserted mid-debounce or mid-hold: async clear, no pulse emitted. Counters saturate nowhere; they only wrap via the rules above.
//  - Channels are fully independent; no shared counters.
// STRUCTURE
//  - paint_pkg: default timing constants (DEBOUNCE_10MS_100M, HOLD_500MS_100M, REPEAT_100MS_100M).
//    Also the hold-FSM state enum {IDLE, HOLD, REPEAT} as 2-bit localparams.
//  - Sub-module paint_input_ch: one channel (sync, debounce, edges, toggle, hold FSM).
//    Instantiated N_CH times by generate loop; the top holds only the selection priority encoder.
// TESTING  (sim params: SYNC_STAGES=2, DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3, N_CH=4)
//  1. Reset: clr_n=0 with raw_in=4'hF -> all outputs 0. Release reset -> level_out=F at cycle 6, press_pulse=F at cycle 7.
//     Same edge: sel_idx=0, sel_valid=1.
//  2. Glitch: raw_in[1] high for 3 cycles then low -> level_out[1], press_pulse[1] stay 0.
//     Then held 4+ cycles -> level_out[1]=1 exactly 6 cycles after the edge.
//  3. Press/release ch2 twice -> press_pulse and release_pulse each two 1-cycle pulses; toggle_out[2] goes 1 then 0.
//  4. Hold ch3 for 20 cycles after level rise -> long_press[3] at cycle 10; repeat_pulse[3] at cycles 10, 13, 16, 19.
//     Release -> long_press 0, no further pulses.
//  5. Simultaneous press ch1 and ch3 -> sel_idx=1. Later press ch3 alone -> sel_idx=3. Release ch3 -> sel_idx stays 3.
//  6. Assert clr_n mid-hold (cycle 7 of HOLD) -> outputs clear immediately, no repeat_pulse.
//     After reset, a still-held input re-debounces per test 1.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared timing defaults and hold-FSM state encoding for the paint-board input bank.
package paint_pkg;

  // Default timing at a 100 MHz system clock
  localparam int DEBOUNCE_10MS_100M = 1_000_000;
  localparam int HOLD_500MS_100M    = 50_000_000;
  localparam int REPEAT_100MS_100M  = 10_000_000;

  // Per-channel hold/auto-repeat FSM states
  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_HOLD   = 2'd1,
    HS_REPEAT = 2'd2
  } hold_state_t;

endpackage

// File: rtl/paint_input_ch.sv
// One conditioned input: synchroniser, debounce, edge pulses, toggle latch,
// long-press flag and auto-repeat pulses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// HS_IDLE   | debounced level low, hold counter parked at 0
// HS_HOLD   | level high, counting towards the long-press threshold
// HS_REPEAT | long press active, emitting repeat_pulse every REPEAT_CYC
module paint_input_ch
  import paint_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_10MS_100M,
  parameter int HOLD_CYC     = HOLD_500MS_100M,
  parameter int REPEAT_CYC   = REPEAT_100MS_100M
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle,
  output logic long_press,
  output logic repeat_pulse,
  output logic press_set
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          dcnt_q, dcnt_nxt;
  logic                   level_nxt;
  logic                   level_d_q;
  logic                   release_set;
  logic [HW-1:0]          hcnt_q;
  hold_state_t            state_q;

  assign s           = sync_q[SYNC_STAGES-1];
  assign press_set   = level & ~level_d_q;
  assign release_set = ~level & level_d_q;

  // Metastability chain; raw is touched by nothing else
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Debounce: count consecutive mismatch cycles, adopt s after DEBOUNCE_CYC of them
  always_comb begin
    level_nxt = level;
    dcnt_nxt  = '0;
    if (s != level) begin
      if (dcnt_q == D_LAST) level_nxt = s;
      else                  dcnt_nxt  = dcnt_q + DW'(1);
    end
  end

  // Debounced level, edge pulses and toggle latch
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dcnt_q        <= '0;
      level         <= 1'b0;
      level_d_q     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      dcnt_q        <= dcnt_nxt;
      level         <= level_nxt;
      level_d_q     <= level;
      press_pulse   <= press_set;
      release_pulse <= release_set;
      toggle        <= toggle ^ press_set;
    end
  end

  // Hold/repeat FSM; follows level_nxt so long_press lands HOLD_CYC after the level rise
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= HS_IDLE;
      hcnt_q       <= '0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      case (state_q)
        HS_IDLE: begin
          hcnt_q <= '0;
          if (level_nxt) state_q <= HS_HOLD;
        end
        HS_HOLD: begin
          if (!level_nxt) begin
            state_q    <= HS_IDLE;
            hcnt_q     <= '0;
            long_press <= 1'b0;
          end else if (hcnt_q == H_LAST) begin
            state_q      <= HS_REPEAT;
            hcnt_q       <= '0;
            long_press   <= 1'b1;
            repeat_pulse <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        HS_REPEAT: begin
          if (!level_nxt) begin
            state_q    <= HS_IDLE;
            hcnt_q     <= '0;
            long_press <= 1'b0;
          end else if (hcnt_q == R_LAST) begin
            hcnt_q       <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: begin
          state_q    <= HS_IDLE;
          hcnt_q     <= '0;
          long_press <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paint_input_bank.sv
// N-channel button/switch conditioner plus last-pressed channel tracking
// for colour/tool select.
module paint_input_bank
  import paint_pkg::*;
#(
  parameter int N_CH         = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_10MS_100M,
  parameter int HOLD_CYC     = HOLD_500MS_100M,
  parameter int REPEAT_CYC   = REPEAT_100MS_100M,
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_CH-1:0]  raw_in,
  output logic [N_CH-1:0]  level_out,
  output logic [N_CH-1:0]  press_pulse,
  output logic [N_CH-1:0]  release_pulse,
  output logic [N_CH-1:0]  toggle_out,
  output logic [N_CH-1:0]  long_press,
  output logic [N_CH-1:0]  repeat_pulse,
  output logic [SEL_W-1:0] sel_idx,
  output logic             sel_valid
);

  logic [N_CH-1:0]  press_set;
  logic [SEL_W-1:0] first_idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    paint_input_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk          (clk),
      .clr_n        (clr_n),
      .raw          (raw_in[g]),
      .level        (level_out[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .toggle       (toggle_out[g]),
      .long_press   (long_press[g]),
      .repeat_pulse (repeat_pulse[g]),
      .press_set    (press_set[g])
    );
  end

  // Lowest index wins among presses that register in the same cycle
  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_set[i]) first_idx = SEL_W'(i);
    end
  end

  // Selection updates on the same edge press_pulse rises; releases never move it
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sel_idx   <= '0;
      sel_valid <= 1'b0;
    end else if (|press_set) begin
      sel_idx   <= first_idx;
      sel_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_paint_input_bank.sv
// Directed bench for paint_input_bank with short timing parameters.
module tb_paint_input_bank;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level_out, press_pulse, release_pulse, toggle_out, long_press, repeat_pulse;
  logic [1:0]   sel_idx;
  logic         sel_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  paint_input_bank #(
    .N_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .HOLD_CYC(10), .REPEAT_CYC(3)
  ) dut (
    .clk(clk), .clr_n(clr_n), .raw_in(raw_in),
    .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .toggle_out(toggle_out), .long_press(long_press), .repeat_pulse(repeat_pulse),
    .sel_idx(sel_idx), .sel_valid(sel_valid)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    raw_in = '0;
    clr_n  = 1'b0;
    tick(2);
    clr_n  = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] all_out;
    raw_in = 4'hF;
    clr_n  = 1'b0;
    tick(2);
    all_out = {level_out, press_pulse, release_pulse, toggle_out, long_press, repeat_pulse, sel_idx, sel_valid};
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", all_out); end
    clr_n = 1'b1;
    tick(5);
    checks++;
    if (level_out !== 4'h0) begin failures++; $display("FAIL reset_level_c5 got=%0h exp=0", level_out); end
    tick(1);
    checks++;
    if (level_out !== 4'hF) begin failures++; $display("FAIL reset_level_c6 got=%0h exp=f", level_out); end
    checks++;
    if (press_pulse !== 4'h0) begin failures++; $display("FAIL reset_press_c6 got=%0h exp=0", press_pulse); end
    tick(1);
    checks++;
    if (press_pulse !== 4'hF) begin failures++; $display("FAIL reset_press_c7 got=%0h exp=f", press_pulse); end
    checks++;
    if ({sel_valid, sel_idx} !== 3'b100) begin failures++; $display("FAIL reset_sel got=%0b exp=100", {sel_valid, sel_idx}); end
    checks++;
    if (toggle_out !== 4'hF) begin failures++; $display("FAIL reset_toggle got=%0h exp=f", toggle_out); end
    tick(1);
    checks++;
    if (press_pulse !== 4'h0) begin failures++; $display("FAIL reset_press_c8 got=%0h exp=0", press_pulse); end
  endtask

  task automatic test_glitch();
    logic seen;
    do_reset();
    raw_in = 4'b0010;
    tick(3);
    raw_in = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      seen = seen | level_out[1] | press_pulse[1];
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL glitch_ignored got=%0b exp=0", seen); end
    raw_in = 4'b0010;
    tick(5);
    checks++;
    if (level_out[1] !== 1'b0) begin failures++; $display("FAIL glitch_level_c5 got=%0b exp=0", level_out[1]); end
    tick(1);
    checks++;
    if (level_out[1] !== 1'b1) begin failures++; $display("FAIL glitch_level_c6 got=%0b exp=1", level_out[1]); end
    tick(1);
    checks++;
    if (press_pulse[1] !== 1'b1) begin failures++; $display("FAIL glitch_press_c7 got=%0b exp=1", press_pulse[1]); end
  endtask

  task automatic test_press_release();
    int np, nr, press_at;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      np = 0; nr = 0; press_at = -1;
      raw_in = 4'b0100;
      for (int c = 1; c <= 10; c++) begin
        tick(1);
        if (press_pulse[2]) begin np++; press_at = c; end
        if (release_pulse[2]) nr++;
      end
      checks++;
      if (press_at !== 7) begin failures++; $display("FAIL pr_press_cycle%0d got=%0d exp=7", k, press_at); end
      checks++;
      if (toggle_out[2] !== ((k == 0) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL pr_toggle%0d got=%0b exp=%0b", k, toggle_out[2], (k == 0));
      end
      raw_in = 4'b0000;
      for (int c = 1; c <= 10; c++) begin
        tick(1);
        if (press_pulse[2]) np++;
        if (release_pulse[2]) nr++;
      end
      checks++;
      if (np !== 1) begin failures++; $display("FAIL pr_press_count%0d got=%0d exp=1", k, np); end
      checks++;
      if (nr !== 1) begin failures++; $display("FAIL pr_release_count%0d got=%0d exp=1", k, nr); end
    end
  endtask

  task automatic test_long_press();
    logic exp_lp, exp_rp, exp_lv;
    do_reset();
    raw_in = 4'b1000;
    tick(6);
    checks++;
    if (level_out[3] !== 1'b1) begin failures++; $display("FAIL lp_level_rise got=%0b exp=1", level_out[3]); end
    for (int c = 1; c <= 26; c++) begin
      tick(1);
      exp_lp = (c >= 10) && (c < 20);
      exp_rp = (c == 10) || (c == 13) || (c == 16) || (c == 19);
      exp_lv = (c < 20);
      checks++;
      if (long_press[3] !== exp_lp) begin failures++; $display("FAIL lp_long_c%0d got=%0b exp=%0b", c, long_press[3], exp_lp); end
      checks++;
      if (repeat_pulse[3] !== exp_rp) begin failures++; $display("FAIL lp_repeat_c%0d got=%0b exp=%0b", c, repeat_pulse[3], exp_rp); end
      checks++;
      if (level_out[3] !== exp_lv) begin failures++; $display("FAIL lp_level_c%0d got=%0b exp=%0b", c, level_out[3], exp_lv); end
      if (c == 14) raw_in = 4'b0000;
    end
  endtask

  task automatic test_select();
    do_reset();
    tick(6);
    checks++;
    if (sel_valid !== 1'b0) begin failures++; $display("FAIL sel_valid_idle got=%0b exp=0", sel_valid); end
    raw_in = 4'b1010;
    tick(7);
    checks++;
    if (press_pulse !== 4'b1010) begin failures++; $display("FAIL sel_dual_press got=%0h exp=a", press_pulse); end
    checks++;
    if ({sel_valid, sel_idx} !== 3'b101) begin failures++; $display("FAIL sel_dual got=%0b exp=101", {sel_valid, sel_idx}); end
    raw_in = 4'b0000;
    tick(10);
    raw_in = 4'b1000;
    tick(7);
    checks++;
    if (sel_idx !== 2'd3) begin failures++; $display("FAIL sel_ch3 got=%0d exp=3", sel_idx); end
    raw_in = 4'b0000;
    tick(8);
    checks++;
    if ({sel_valid, sel_idx} !== 3'b111) begin failures++; $display("FAIL sel_after_release got=%0b exp=111", {sel_valid, sel_idx}); end
  endtask

  task automatic test_reset_mid_hold();
    logic [26:0] all_out;
    logic        rp_seen;
    do_reset();
    raw_in = 4'b1000;
    tick(6);
    tick(7);
    checks++;
    if (long_press[3] !== 1'b0) begin failures++; $display("FAIL mh_long_c7 got=%0b exp=0", long_press[3]); end
    clr_n = 1'b0;
    #1;
    all_out = {level_out, press_pulse, release_pulse, toggle_out, long_press, repeat_pulse, sel_idx, sel_valid};
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL mh_clear got=%0h exp=0", all_out); end
    rp_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      rp_seen = rp_seen | (|repeat_pulse) | (|long_press);
    end
    checks++;
    if (rp_seen !== 1'b0) begin failures++; $display("FAIL mh_no_repeat got=%0b exp=0", rp_seen); end
    clr_n = 1'b1;
    tick(5);
    checks++;
    if (level_out !== 4'h0) begin failures++; $display("FAIL mh_level_c5 got=%0h exp=0", level_out); end
    tick(1);
    checks++;
    if (level_out !== 4'h8) begin failures++; $display("FAIL mh_level_c6 got=%0h exp=8", level_out); end
    tick(1);
    checks++;
    if (press_pulse !== 4'h8) begin failures++; $display("FAIL mh_press_c7 got=%0h exp=8", press_pulse); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_long_press();
    test_select();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
